// File: rtl/dcache_line_controller.sv
// Control FSM for the 2-way, write-back, write-allocate LC-3b data cache.
// Decodes Mealy strobes for the line datapath and the physical-memory port.
// It also keeps saturating hit and miss counters.
module dcache_line_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 lru,
    input  logic                 pmem_resp,
    input  logic                 perf_clear,
    output logic                 mem_resp,
    output logic [1:0]           load_data,
    output logic [1:0]           load_tag,
    output logic [1:0]           set_valid,
    output logic [1:0]           set_dirty,
    output logic [1:0]           clear_dirty,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic                 insert_enable,
    output logic                 data_in_sel,
    output logic                 pmem_addr_sel,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    state_t next_state;
    logic   victim;
    logic   req;
    logic   hit;
    logic   hit_way;
    logic   victim_dirty;
    logic   hit_event;
    logic   miss_event;
    logic   unused_byte_mask;

    // Saturating increment: the counter sticks at all ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value)
            return value;
        return value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The byte mask is consumed by the merge unit in the datapath, not here.
    assign unused_byte_mask = ^mem_byte_enable;

    // A simultaneous read and write is handled as a write; way 0 wins a double hit.
    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;
    assign victim_dirty = lru ? (valid1 & dirty1) : (valid0 & dirty0);
    assign hit_event    = (state == IDLE) && req && hit;
    assign miss_event   = (state == IDLE) && req && !hit;

    // State register and victim latch; reset returns to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state <= next_state;
            if (miss_event)
                victim <= lru;
        end
    end

    // Next-state logic: a miss walks through an optional writeback, then the fill.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (miss_event)
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                if (pmem_resp)
                    next_state = ALLOCATE;
            end
            ALLOCATE: begin
                if (pmem_resp)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Mealy output decode; miss-phase strobes target the latched victim only.
    always_comb begin
        mem_resp      = 1'b0;
        load_data     = 2'b00;
        load_tag      = 2'b00;
        set_valid     = 2'b00;
        set_dirty     = 2'b00;
        clear_dirty   = 2'b00;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        insert_enable = 1'b0;
        data_in_sel   = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit_event) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way;
                    if (mem_write) begin
                        load_data[hit_way] = 1'b1;
                        set_dirty[hit_way] = 1'b1;
                        insert_enable      = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data[victim]   = 1'b1;
                    load_tag[victim]    = 1'b1;
                    set_valid[victim]   = 1'b1;
                    clear_dirty[victim] = 1'b1;
                    data_in_sel         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Performance counters; perf_clear overrides any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (perf_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_event)
                hit_count <= sat_inc(hit_count);
            if (miss_event)
                miss_count <= sat_inc(miss_count);
        end
    end

endmodule

// File: tb/tb_dcache_line_controller.sv
// Self-checking bench for dcache_line_controller.
// Each CPU transaction is scripted from the cache protocol: a hit responds at once.
// A miss optionally writes the victim back, fills it, then hits.
module tb_dcache_line_controller;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [1:0]    mem_byte_enable;
    logic          hit0, hit1, dirty0, dirty1, valid0, valid1, lru;
    logic          pmem_resp, perf_clear;
    logic          mem_resp;
    logic [1:0]    load_data, load_tag, set_valid, set_dirty, clear_dirty;
    logic          load_lru, lru_in, insert_enable, data_in_sel;
    logic          pmem_addr_sel, pmem_read, pmem_write;
    logic [CW-1:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int hits_m = 0;
    int misses_m = 0;

    dcache_line_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .hit0(hit0), .hit1(hit1),
        .dirty0(dirty0), .dirty1(dirty1), .valid0(valid0), .valid1(valid1),
        .lru(lru), .pmem_resp(pmem_resp), .perf_clear(perf_clear),
        .mem_resp(mem_resp), .load_data(load_data), .load_tag(load_tag),
        .set_valid(set_valid), .set_dirty(set_dirty), .clear_dirty(clear_dirty),
        .load_lru(load_lru), .lru_in(lru_in), .insert_enable(insert_enable),
        .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // All strobes in one vector: resp, load_data, load_tag, set_valid, set_dirty,
    // clear_dirty, load_lru, lru_in, insert_enable, data_in_sel, addr_sel, read, write.
    function automatic logic [17:0] outs();
        return {mem_resp, load_data, load_tag, set_valid, set_dirty, clear_dirty,
                load_lru, lru_in, insert_enable, data_in_sel, pmem_addr_sel,
                pmem_read, pmem_write};
    endfunction

    function automatic logic [17:0] e_hit(input logic way, input logic wr);
        logic [1:0] oh;
        oh = way ? 2'b10 : 2'b01;
        return {1'b1, wr ? oh : 2'b00, 2'b00, 2'b00, wr ? oh : 2'b00, 2'b00,
                1'b1, ~way, wr, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic logic [17:0] e_wb();
        return {1'b0, 10'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    endfunction

    function automatic logic [17:0] e_alloc(input logic resp, input logic way);
        logic [1:0] oh;
        oh = resp ? (way ? 2'b10 : 2'b01) : 2'b00;
        return {1'b0, oh, oh, oh, 2'b00, oh, 1'b0, 1'b0, 1'b0, resp, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, updating the counter model with what this cycle should count.
    task automatic tick(input logic hinc, input logic minc);
        if (perf_clear) begin
            hits_m   = 0;
            misses_m = 0;
        end else begin
            if (hinc && hits_m < MAXC) hits_m++;
            if (minc && misses_m < MAXC) misses_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"}, 32'(hit_count), 32'(hits_m));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(misses_m));
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        pmem_resp = 1'b0;
        perf_clear = 1'b0;
    endtask

    // One CPU transaction from request to response (or to fill completion if dropped).
    task automatic txn(input logic rd, input logic wr, input logic [1:0] be,
                       input logic h0, input logic h1,
                       input logic v0, input logic v1, input logic d0, input logic d1,
                       input logic lr, input int wlat, input int rlat,
                       input logic drop, input logic toggle, input logic clr);
        logic v, dv, is_wr;
        mem_read = rd; mem_write = wr; mem_byte_enable = be;
        hit0 = h0; hit1 = h1; valid0 = v0; valid1 = v1; dirty0 = d0; dirty1 = d1;
        lru = lr; perf_clear = clr; pmem_resp = 1'b0;
        is_wr = wr;
        #2;
        if (h0 | h1) begin
            check("hit_strobes", 32'(outs()), 32'(e_hit(h0 ? 1'b0 : 1'b1, is_wr)));
            tick(1'b1, 1'b0);
            go_idle();
            check_counters("hit");
            return;
        end
        check("miss_first_cycle", 32'(outs()), 32'(0));
        tick(1'b0, 1'b1);
        perf_clear = 1'b0;
        v  = lr;
        dv = lr ? (v1 & d1) : (v0 & d0);
        if (drop) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        if (dv) begin
            for (int i = 0; i <= wlat; i++) begin
                if (toggle) lru = ~lru;
                pmem_resp = (i == wlat);
                #2;
                check("writeback", 32'(outs()), 32'(e_wb()));
                tick(1'b0, 1'b0);
            end
        end
        for (int i = 0; i <= rlat; i++) begin
            if (toggle) lru = ~lru;
            pmem_resp = (i == rlat);
            #2;
            check("allocate", 32'(outs()), 32'(e_alloc(pmem_resp, v)));
            tick(1'b0, 1'b0);
        end
        pmem_resp = 1'b0;
        if (toggle) lru = ~lru;
        if (drop) begin
            #2;
            check("after_drop_idle", 32'(outs()), 32'(0));
            tick(1'b0, 1'b0);
        end else begin
            hit0 = (v == 1'b0);
            hit1 = (v == 1'b1);
            #2;
            check("refill_hit", 32'(outs()), 32'(e_hit(v, is_wr)));
            tick(1'b1, 1'b0);
        end
        go_idle();
        check_counters("miss");
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        mem_byte_enable = 2'b00;
        valid0 = 1'b0; valid1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0;
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'(0));
        check("reset_hit_count", 32'(hit_count), 32'(0));
        check("reset_miss_count", 32'(miss_count), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_req", 32'(outs()), 32'(0));

        // Read hit way 0, then write hit way 1 with byte mask 01.
        txn(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("first_hit_count", 32'(hit_count), 32'(1));
        txn(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Clean read miss on way 0, memory answers on the fifth read cycle.
        txn(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0);
        check("first_miss_count", 32'(miss_count), 32'(1));

        // Dirty write miss on way 1 with lru toggling during the miss.
        txn(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 2, 1'b0, 1'b1, 1'b0);

        // Double hit resolves to way 0; read+write together acts as a write.
        txn(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Requester drops mid-miss; fill still completes.
        txn(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 1'b0);

        // Reset asserted while writing back.
        mem_write = 1'b1; lru = 1'b1; valid1 = 1'b1; dirty1 = 1'b1; hit0 = 1'b0; hit1 = 1'b0;
        #2;
        check("pre_reset_miss", 32'(outs()), 32'(0));
        tick(1'b0, 1'b1);
        #2;
        check("pre_reset_writeback", 32'(outs()), 32'(e_wb()));
        rst_n = 1'b0;
        #1;
        hits_m = 0;
        misses_m = 0;
        check("reset_mid_wb_outputs", 32'(outs()), 32'(0));
        check("reset_mid_wb_pmem_write", 32'(pmem_write), 32'(0));
        check_counters("reset_mid_wb");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hit0 = 1'b1;
        #2;
        check("after_reset_is_idle", 32'(outs()), 32'(e_hit(1'b0, 1'b1)));
        tick(1'b1, 1'b0);
        go_idle();
        check_counters("after_reset");

        // Saturation: 17 more hits.
        for (int i = 0; i < 17; i++)
            txn(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("hit_count_saturated", 32'(hit_count), 32'(MAXC));

        // perf_clear together with a hit wins over the increment.
        txn(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("perf_clear_hit_count", 32'(hit_count), 32'(0));

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            logic wr, rd;
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            r  = int'($urandom_range(0, 5));
            txn(rd, wr, 2'($urandom),
                r == 1 || r == 3, r == 2 || r == 3,
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
